// File: rtl/fifo_arbiter_pkg.sv
// Shared types and constants for the round-robin FIFO drain and packet serialiser.
package fifo_arbiter_pkg;

    localparam int PKT_W_DEF     = 128;
    localparam int WORD_W_DEF    = 32;
    localparam int WORDS_PER_PKT = PKT_W_DEF / WORD_W_DEF;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        SEND
    } state_t;

    typedef logic [WORD_W_DEF-1:0] word_t;

endpackage

// File: rtl/fifo_arbiter_rr_picker.sv
// Combinational round-robin picker: searches upward from ptr+1, so the source at ptr
// (the one served last) has the lowest priority.
module rr_picker
    import fifo_arbiter_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SRC_W = 2
) (
    input  logic [N_SRC-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic [SRC_W-1:0] win,
    output logic             vld
);

    int j;

    // Walk from the farthest candidate back to ptr+1 so the nearest request wins last.
    always_comb begin
        win = '0;
        vld = 1'b0;
        j   = 0;
        for (int k = N_SRC; k >= 1; k--) begin
            j = (int'(ptr) + k) % N_SRC;
            if (req[SRC_W'(j)]) begin
                win = SRC_W'(j);
                vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_arbiter.sv
// Drains N_SRC non-FWFT packet FIFOs in round-robin order and serialises each packet
// most-significant word first onto a valid/ready word stream.
module fifo_arbiter
    import fifo_arbiter_pkg::*;
#(
    parameter int N_SRC  = 4,
    parameter int PKT_W  = PKT_W_DEF,
    parameter int WORD_W = WORD_W_DEF,
    localparam int SRC_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_SRC-1:0]       SRC_EMPTY,
    input  logic [N_SRC*PKT_W-1:0] SRC_DATA,
    output logic [N_SRC-1:0]       SRC_READ,
    output logic [WORD_W-1:0]      OUT_DATA,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic                   OUT_SOP,
    output logic                   OUT_EOP,
    output logic [SRC_W-1:0]       OUT_SRC,
    output logic                   BUSY,
    output logic [15:0]            PKT_COUNT
);

    localparam int WORDS = PKT_W / WORD_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    state_t             state, state_nxt;
    logic [SRC_W-1:0]   grant, ptr, win;
    logic               win_vld;
    logic [N_SRC-1:0]   req;
    logic [PKT_W-1:0]   src_pkt [N_SRC];
    logic [PKT_W-1:0]   shreg;
    logic [IDX_W-1:0]   idx;
    logic [15:0]        pkt_count;
    logic               accept, last;

    assign req = ~SRC_EMPTY;

    for (genvar g = 0; g < N_SRC; g++) begin : g_slice
        assign src_pkt[g] = SRC_DATA[g*PKT_W +: PKT_W];
    end

    rr_picker #(.N_SRC(N_SRC), .SRC_W(SRC_W)) u_picker (
        .req (req),
        .ptr (ptr),
        .win (win),
        .vld (win_vld)
    );

    always_comb begin
        state_nxt = state;
        SRC_READ  = '0;
        OUT_VALID = 1'b0;
        OUT_DATA  = '0;
        OUT_SOP   = 1'b0;
        OUT_EOP   = 1'b0;
        accept    = 1'b0;
        last      = (idx == IDX_W'(WORDS - 1));
        case (state)
            IDLE: if (win_vld) state_nxt = READ;
            READ: begin
                SRC_READ[grant] = 1'b1;
                state_nxt       = WAIT;
            end
            WAIT: state_nxt = SEND;
            SEND: begin
                OUT_VALID = 1'b1;
                OUT_DATA  = shreg[PKT_W-1 -: WORD_W];
                OUT_SOP   = (idx == '0);
                OUT_EOP   = last;
                accept    = OUT_READY;
                if (accept && last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control registers: the only state a mid-packet reset has to clean up.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= IDLE;
            grant     <= '0;
            ptr       <= SRC_W'(N_SRC - 1);
            pkt_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && win_vld) grant <= win;
            if (accept && last) begin
                pkt_count <= pkt_count + 16'd1;
                ptr       <= grant;
            end
        end
    end

    // FIFO dout is valid the cycle after rd_en, i.e. during WAIT.
    always_ff @(posedge CLK) begin
        if (state == WAIT) begin
            shreg <= src_pkt[grant];
            idx   <= '0;
        end else if (accept) begin
            shreg <= shreg << WORD_W;
            idx   <= idx + IDX_W'(1);
        end
    end

    assign BUSY      = (state != IDLE);
    assign OUT_SRC   = grant;
    assign PKT_COUNT = pkt_count;

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter: behavioural FIFOs, a word scoreboard and round-robin vector table.
module tb_fifo_arbiter;
    import fifo_arbiter_pkg::*;

    localparam int N_SRC = 4;
    localparam int PKT_W = 128;
    localparam int WORD_W = 32;

    logic                   CLK = 1'b0;
    logic                   RESET;
    logic [N_SRC-1:0]       SRC_EMPTY;
    logic [N_SRC*PKT_W-1:0] SRC_DATA;
    logic [N_SRC-1:0]       SRC_READ;
    logic [WORD_W-1:0]      OUT_DATA;
    logic                   OUT_VALID;
    logic                   OUT_READY;
    logic                   OUT_SOP;
    logic                   OUT_EOP;
    logic [1:0]             OUT_SRC;
    logic                   BUSY;
    logic [15:0]            PKT_COUNT;

    fifo_arbiter #(.N_SRC(N_SRC), .PKT_W(PKT_W), .WORD_W(WORD_W)) dut (
        .CLK(CLK), .RESET(RESET), .SRC_EMPTY(SRC_EMPTY), .SRC_DATA(SRC_DATA),
        .SRC_READ(SRC_READ), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY), .OUT_SOP(OUT_SOP), .OUT_EOP(OUT_EOP),
        .OUT_SRC(OUT_SRC), .BUSY(BUSY), .PKT_COUNT(PKT_COUNT)
    );

    always #5 CLK = ~CLK;

    // Behavioural non-FWFT source FIFOs: stimulus owns wp/mem, this model owns rp/dout.
    logic [PKT_W-1:0] mem [N_SRC][16];
    logic [PKT_W-1:0] dout [N_SRC];
    int wp [N_SRC];
    int rp [N_SRC] = '{default: 0};
    int rd_cnt [N_SRC] = '{default: 0};
    int bad_rd = 0;
    int multi_rd = 0;
    int cyc = 0;

    for (genvar g = 0; g < N_SRC; g++) begin : g_fifo
        assign SRC_EMPTY[g] = (wp[g] == rp[g]);
        assign SRC_DATA[g*PKT_W +: PKT_W] = dout[g];
    end

    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if ($countones(SRC_READ) > 1) multi_rd <= multi_rd + 1;
        for (int i = 0; i < N_SRC; i++) begin
            if (SRC_READ[i]) begin
                rd_cnt[i] <= rd_cnt[i] + 1;
                if (wp[i] == rp[i]) bad_rd <= bad_rd + 1;
                else begin
                    dout[i] <= mem[i][4'(rp[i])];
                    rp[i]   <= rp[i] + 1;
                end
            end
        end
    end

    typedef struct packed {
        word_t      data;
        logic       sop;
        logic       eop;
        logic [1:0] src;
    } exp_t;

    typedef struct {
        logic [3:0]  mask;
        int          reps;
        logic [15:0] order;
        int          n;
        logic [15:0] cnt;
    } vec_t;

    exp_t exp_q[$];
    int   sop_cyc[$];
    int   checks = 0;
    int   failures = 0;
    int   acc_pkt = 0;
    logic prev_stall = 1'b0;
    logic [WORD_W-1:0] prev_data;
    logic prev_sop, prev_eop;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [127:0] pkt_data(input int r, input int s, input int rep);
        return {8'(r), 8'(s), 8'(rep), 8'hA5, 32'hCAFE_0000 + 32'(r * 16 + s),
                32'h1357_9BDF ^ 32'(s << 8) ^ 32'(rep), 32'h0BAD_F00D + 32'(rep)};
    endfunction

    task automatic push_pkt(input int s, input logic [127:0] d);
        mem[s][4'(wp[s])] = d;
        wp[s]++;
    endtask

    task automatic expect_pkt(input int s, input logic [127:0] d);
        exp_t e;
        for (int w = 0; w < 4; w++) begin
            e.data = d[127 - 32*w -: 32];
            e.sop  = (w == 0);
            e.eop  = (w == 3);
            e.src  = 2'(s);
            exp_q.push_back(e);
        end
    endtask

    // Drive rdy/rst at the falling edge, then score what the next rising edge will see.
    task automatic step(input logic rdy, input logic rst);
        exp_t e;
        @(negedge CLK);
        OUT_READY = rdy;
        RESET     = rst;
        if (prev_stall) begin
            check("stall_data", OUT_DATA, prev_data);
            check("stall_sop", OUT_SOP, prev_sop);
            check("stall_eop", OUT_EOP, prev_eop);
        end
        if (OUT_VALID && rdy && !rst) begin
            if (exp_q.size() == 0) check("extra_word", OUT_DATA, 'x);
            else begin
                e = exp_q.pop_front();
                check("word_data", OUT_DATA, e.data);
                check("word_sop", OUT_SOP, e.sop);
                check("word_eop", OUT_EOP, e.eop);
                check("word_src", OUT_SRC, e.src);
            end
            if (OUT_SOP) sop_cyc.push_back(cyc);
            acc_pkt = OUT_EOP ? 0 : acc_pkt + 1;
        end
        prev_stall = OUT_VALID && !rdy && !rst;
        prev_data  = OUT_DATA;
        prev_sop   = OUT_SOP;
        prev_eop   = OUT_EOP;
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || BUSY) && k < budget) begin
            step(1'b1, 1'b0);
            k++;
        end
        check("drain_timeout", k >= budget, 0);
    endtask

    task automatic wait_acc(input int words, input logic rst_after);
        int k = 0;
        while (acc_pkt != words && k < 40) begin
            step(1'b1, 1'b0);
            k++;
        end
        check("acc_timeout", k >= 40, 0);
    endtask

    function automatic int total_rd();
        return rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3];
    endfunction

    vec_t tv [5];
    logic [8:0] rd_h, sop_h, eop_h, busy_h;
    int sr [N_SRC];
    int base_rd, s_k;

    initial begin
        RESET = 1'b1;
        OUT_READY = 1'b1;
        for (int i = 0; i < N_SRC; i++) wp[i] = 0;

        tv[0] = '{mask: 4'b1111, reps: 1, order: 16'h1B00, n: 4, cnt: 16'd4};
        tv[1] = '{mask: 4'b0101, reps: 2, order: 16'h2200, n: 4, cnt: 16'd8};
        tv[2] = '{mask: 4'b1010, reps: 1, order: 16'hD000, n: 2, cnt: 16'd10};
        tv[3] = '{mask: 4'b0110, reps: 1, order: 16'h9000, n: 2, cnt: 16'd12};
        tv[4] = '{mask: 4'b1001, reps: 1, order: 16'hC000, n: 2, cnt: 16'd14};

        repeat (3) step(1'b1, 1'b1);
        check("rst_valid", OUT_VALID, 0);
        check("rst_sop", OUT_SOP, 0);
        check("rst_eop", OUT_EOP, 0);
        check("rst_busy", BUSY, 0);
        check("rst_data", OUT_DATA, 0);
        check("rst_src", OUT_SRC, 0);
        check("rst_count", PKT_COUNT, 0);
        check("rst_read", SRC_READ, 0);
        step(1'b1, 1'b0);

        // Single packet from source 0 with cycle-exact timing.
        push_pkt(0, 128'h1000_3500_DEAD_BEEF_DEAD_BEEF_0000_1234);
        exp_q.push_back('{32'h1000_3500, 1'b1, 1'b0, 2'd0});
        exp_q.push_back('{32'hDEAD_BEEF, 1'b0, 1'b0, 2'd0});
        exp_q.push_back('{32'hDEAD_BEEF, 1'b0, 1'b0, 2'd0});
        exp_q.push_back('{32'h0000_1234, 1'b0, 1'b1, 2'd0});
        rd_h = '0; sop_h = '0; eop_h = '0; busy_h = '0;
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 1'b0);
            rd_h[k]   = |SRC_READ;
            sop_h[k]  = OUT_VALID && OUT_SOP;
            eop_h[k]  = OUT_VALID && OUT_EOP;
            busy_h[k] = BUSY;
        end
        check("t1_read_cycles", rd_h, 9'b0_0000_0010);
        check("t1_sop_cycles", sop_h, 9'b0_0000_1000);
        check("t1_eop_cycles", eop_h, 9'b0_0100_0000);
        check("t1_busy_cycles", busy_h, 9'b0_0111_1110);
        check("t1_words_left", exp_q.size(), 0);
        check("t1_count", PKT_COUNT, 1);
        check("t1_src0_reads", rd_cnt[0], 1);

        step(1'b1, 1'b1);
        step(1'b1, 1'b0);

        // Round-robin vector table; all of a row's packets are loaded while idle.
        for (int r = 0; r < 5; r++) begin
            base_rd = total_rd();
            for (int s = 0; s < N_SRC; s++) begin
                sr[s] = 0;
                if (tv[r].mask[s])
                    for (int p = 0; p < tv[r].reps; p++) push_pkt(s, pkt_data(r, s, p));
            end
            for (int k = 0; k < tv[r].n; k++) begin
                s_k = int'(tv[r].order[15 - 2*k -: 2]);
                expect_pkt(s_k, pkt_data(r, s_k, sr[s_k]));
                sr[s_k]++;
            end
            drain(200);
            check("rr_count", PKT_COUNT, tv[r].cnt);
            check("rr_reads", total_rd() - base_rd, tv[r].n);
        end

        // Reset while word 1 of the source-1 packet is on the bus.
        base_rd = total_rd();
        for (int s = 0; s < 3; s++) push_pkt(s, pkt_data(9, s, 0));
        expect_pkt(1, pkt_data(9, 1, 0));
        expect_pkt(0, pkt_data(9, 0, 0));
        expect_pkt(2, pkt_data(9, 2, 0));
        wait_acc(1, 1'b0);
        step(1'b0, 1'b1);
        repeat (3) void'(exp_q.pop_front());
        acc_pkt = 0;
        step(1'b1, 1'b0);
        check("mid_rst_valid", OUT_VALID, 0);
        check("mid_rst_busy", BUSY, 0);
        check("mid_rst_count", PKT_COUNT, 0);
        drain(200);
        check("mid_rst_count_after", PKT_COUNT, 2);
        check("mid_rst_src1_reads", rd_cnt[1] - (base_rd - base_rd) - 0 >= 0 ? total_rd() - base_rd : -1, 3);

        // Five-cycle stall on word 2.
        base_rd = total_rd();
        push_pkt(2, pkt_data(10, 2, 0));
        expect_pkt(2, pkt_data(10, 2, 0));
        wait_acc(2, 1'b0);
        repeat (5) step(1'b0, 1'b0);
        check("bp_eop_stalled", OUT_EOP, 0);
        check("bp_reads", total_rd() - base_rd, 1);
        drain(100);
        check("bp_count", PKT_COUNT, 3);

        // Back-to-back packets from source 1 alone.
        base_rd = total_rd();
        sop_cyc.delete();
        for (int p = 0; p < 3; p++) begin
            push_pkt(1, pkt_data(11, 1, p));
            expect_pkt(1, pkt_data(11, 1, p));
        end
        drain(100);
        check("b2b_sops", sop_cyc.size(), 3);
        if (sop_cyc.size() == 3) begin
            check("b2b_period0", sop_cyc[1] - sop_cyc[0], 7);
            check("b2b_period1", sop_cyc[2] - sop_cyc[1], 7);
        end
        check("b2b_reads", total_rd() - base_rd, 3);

        // Packet counter wrap.
        force dut.pkt_count = 16'hFFFF;
        step(1'b1, 1'b0);
        release dut.pkt_count;
        push_pkt(3, pkt_data(12, 3, 0));
        expect_pkt(3, pkt_data(12, 3, 0));
        drain(100);
        check("wrap_count", PKT_COUNT, 0);

        check("empty_reads", bad_rd, 0);
        check("multi_hot_reads", multi_rd, 0);
        check("words_left", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
